cnt_wrap_monitor: RTL and testbench



---
 rtl/cnt_wrap_monitor.sv | 145 ++++++++++++++
 tb/tb_cnt_wrap_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_wrap_monitor.sv
// cnt_wrap_monitor
//
// Samples a narrow modular count from an upstream accumulator and rebuilds
// a wide monotonic count from it. Each wrap-around of the narrow count
// queues the upper bits of the rebuilt count in a small FIFO. The FIFO is
// drained through a valid/ready handshake.
//
// Ports
//   clock       in   sole clock; all state updates on the rising edge
//   reset       in   synchronous, active-high; dominates every other input
//   en          in   sample strobe; cnt is consumed only when en=1
//   cnt         in   WIDTH-bit modular count from the upstream counter
//   ext_cnt     out  WIDTH+EXT-bit reconstructed count (registered)
//   primed      out  high once the first sample after reset has been taken
//   wrap_valid  out  FIFO head valid
//   wrap_ready  in   consumer accepts the head when valid and ready are high
//   wrap_data   out  upper EXT bits of ext_cnt captured at the wrap
//   level       out  FIFO occupancy
//   overflow    out  sticky; a wrap event was dropped because the FIFO was full
module cnt_wrap_monitor #(
    parameter int WIDTH = 4,
    parameter int EXT   = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         cnt,
    output logic [WIDTH+EXT-1:0]     ext_cnt,
    output logic                     primed,
    output logic                     wrap_valid,
    input  logic                     wrap_ready,
    output logic [EXT-1:0]           wrap_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TOT_W = WIDTH + EXT;

    typedef enum logic {UNPRIMED, RUN} state_e;

    // Forward distance between two samples of the modular count.
    function automatic logic [WIDTH-1:0] mod_diff(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] prv);
        return cur - prv;
    endfunction

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [TOT_W-1:0]     ext_q, ext_d;
    logic [EXT-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 valid_q, valid_d;
    logic [EXT-1:0]       data_q, data_d;

    logic                 wrap_evt;
    logic                 full;
    logic                 pop;
    logic                 push;

    // Sample stage: FSM, wide-count reconstruction and wrap detection.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        ext_d    = ext_q;
        wrap_evt = 1'b0;
        case (state_q)
            UNPRIMED: begin
                if (en) begin
                    prev_d  = cnt;
                    ext_d   = {{EXT{1'b0}}, cnt};
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    ext_d    = ext_q + {{EXT{1'b0}}, mod_diff(cnt, prev_q)};
                    prev_d   = cnt;
                    wrap_evt = (cnt < prev_q);
                end
            end
            default: state_d = UNPRIMED;
        endcase
    end

    // FIFO stage. The visible head is a registered copy of the memory head;
    // it is computed from the occupancy before this edge's push, which is
    // what delays a push into an empty FIFO by one cycle.
    always_comb begin
        pop        = valid_q & wrap_ready;
        full       = (level_q == LVL_W'(DEPTH));
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push       = wrap_evt & (~full | pop);
        overflow_d = overflow_q | (wrap_evt & full & ~pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        valid_d    = ((level_q - LVL_W'(pop)) != '0);
        data_d     = valid_d ? mem_q[rd_ptr_d] : data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= UNPRIMED;
            prev_q     <= '0;
            ext_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            ext_q      <= ext_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    // Storage is not reset; occupancy and pointers define what is live.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= ext_d[TOT_W-1:WIDTH];
        end
    end

    assign ext_cnt    = ext_q;
    assign primed     = (state_q == RUN);
    assign wrap_valid = valid_q;
    assign wrap_data  = data_q;
    assign level      = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cnt_wrap_monitor.sv
module tb_cnt_wrap_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  cnt = '0;
    logic        wrap_ready = 1'b0;

    // Default instance: WIDTH=4, EXT=12, DEPTH=4
    logic [15:0] ext_cnt;
    logic        primed, wrap_valid, overflow;
    logic [11:0] wrap_data;
    logic [2:0]  level;

    // Narrow-extension instance: EXT=2, so ext_cnt rolls over at 64
    logic [5:0]  ext_cnt2;
    logic        primed2, wrap_valid2, overflow2;
    logic [1:0]  wrap_data2;
    logic [2:0]  level2;

    int vectors = 0;
    int miscompares = 0;

    cnt_wrap_monitor #(.WIDTH(4), .EXT(12), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .en(en), .cnt(cnt),
        .ext_cnt(ext_cnt), .primed(primed), .wrap_valid(wrap_valid),
        .wrap_ready(wrap_ready), .wrap_data(wrap_data), .level(level),
        .overflow(overflow)
    );

    cnt_wrap_monitor #(.WIDTH(4), .EXT(2), .DEPTH(4)) dut2 (
        .clock(clock), .reset(reset), .en(en), .cnt(cnt),
        .ext_cnt(ext_cnt2), .primed(primed2), .wrap_valid(wrap_valid2),
        .wrap_ready(wrap_ready), .wrap_data(wrap_data2), .level(level2),
        .overflow(overflow2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; en = 1'b0; wrap_ready = 1'b0; cnt = '0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        vectors++;
        if ({ext_cnt, primed, wrap_valid, wrap_data, level, overflow} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got ext=%0d primed=%0b valid=%0b data=%0d level=%0d ovf=%0b required all 0",
                     ext_cnt, primed, wrap_valid, wrap_data, level, overflow);
        end
    endtask

    task automatic test_prime_step();
        int seq[5]     = '{1, 11, 5, 15, 9};
        int exp_ext[5] = '{1, 11, 21, 31, 41};
        int exp_lvl[5] = '{0, 0, 1, 1, 2};
        int exp_vld[5] = '{0, 0, 0, 1, 1};
        do_reset(2);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cnt = 4'(seq[i]);
            tick();
            vectors++;
            if (ext_cnt !== 16'(exp_ext[i]) || primed !== 1'b1) begin
                miscompares++;
                $display("FAIL prime_ext[%0d] got ext=%0d primed=%0b required ext=%0d primed=1",
                         i, ext_cnt, primed, exp_ext[i]);
            end
            vectors++;
            if (level !== 3'(exp_lvl[i]) || wrap_valid !== 1'(exp_vld[i])) begin
                miscompares++;
                $display("FAIL prime_fifo[%0d] got level=%0d valid=%0b required level=%0d valid=%0d",
                         i, level, wrap_valid, exp_lvl[i], exp_vld[i]);
            end
        end
        en = 1'b0;
        vectors++;
        if (wrap_data !== 12'd1) begin
            miscompares++;
            $display("FAIL prime_head got %0d required 1", wrap_data);
        end
        wrap_ready = 1'b1;
        tick();
        vectors++;
        if (wrap_valid !== 1'b1 || wrap_data !== 12'd2 || level !== 3'd1) begin
            miscompares++;
            $display("FAIL prime_pop1 got valid=%0b data=%0d level=%0d required 1/2/1",
                     wrap_valid, wrap_data, level);
        end
        tick();
        vectors++;
        if (wrap_valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL prime_pop2 got valid=%0b level=%0d required 0/0", wrap_valid, level);
        end
        wrap_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset(2);
        en = 1'b1; cnt = 4'd3;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cnt = 4'($urandom_range(0, 15));
            tick();
            vectors++;
            if (ext_cnt !== 16'd3 || level !== 3'd0) begin
                miscompares++;
                $display("FAIL hold[%0d] got ext=%0d level=%0d required ext=3 level=0", i, ext_cnt, level);
            end
        end
        en = 1'b1; cnt = 4'd4;
        tick();
        vectors++;
        if (ext_cnt !== 16'd4 || level !== 3'd0 || wrap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_resume got ext=%0d level=%0d valid=%0b required 4/0/0",
                     ext_cnt, level, wrap_valid);
        end
        en = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset(2);
        en = 1'b1; cnt = 4'd0;
        tick();
        for (int w = 1; w <= 5; w++) begin
            cnt = 4'd15; tick();
            cnt = 4'd0;  tick();
            vectors++;
            if (ext_cnt !== 16'(16 * w) || level !== 3'((w < 4) ? w : 4) || overflow !== (w == 5)) begin
                miscompares++;
                $display("FAIL ovf_wrap[%0d] got ext=%0d level=%0d ovf=%0b required ext=%0d level=%0d ovf=%0b",
                         w, ext_cnt, level, overflow, 16 * w, (w < 4) ? w : 4, w == 5);
            end
        end
        en = 1'b0;
        vectors++;
        if (wrap_valid !== 1'b1 || wrap_data !== 12'd1) begin
            miscompares++;
            $display("FAIL ovf_head got valid=%0b data=%0d required 1/1", wrap_valid, wrap_data);
        end
        wrap_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (wrap_valid !== (k < 4) || (k < 4 && wrap_data !== 12'(k + 1)) ||
                level !== 3'(4 - k) || overflow !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_pop[%0d] got valid=%0b data=%0d level=%0d ovf=%0b required valid=%0b data=%0d level=%0d ovf=1",
                         k, wrap_valid, wrap_data, level, overflow, k < 4, k + 1, 4 - k);
            end
        end
        wrap_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset(2);
        en = 1'b1; cnt = 4'd0;
        tick();
        for (int w = 1; w <= 4; w++) begin
            cnt = 4'd15; tick();
            cnt = 4'd0;  tick();
        end
        cnt = 4'd15; tick();
        vectors++;
        if (level !== 3'd4 || wrap_data !== 12'd1) begin
            miscompares++;
            $display("FAIL full_pre got level=%0d data=%0d required 4/1", level, wrap_data);
        end
        cnt = 4'd0; wrap_ready = 1'b1;
        tick();
        en = 1'b0;
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b0 || wrap_data !== 12'd2) begin
            miscompares++;
            $display("FAIL full_pushpop got level=%0d ovf=%0b data=%0d required 4/0/2",
                     level, overflow, wrap_data);
        end
        for (int k = 3; k <= 6; k++) begin
            tick();
            vectors++;
            if (wrap_valid !== (k <= 5) || (k <= 5 && wrap_data !== 12'(k))) begin
                miscompares++;
                $display("FAIL full_drain[%0d] got valid=%0b data=%0d required valid=%0b data=%0d",
                         k, wrap_valid, wrap_data, k <= 5, k);
            end
        end
        wrap_ready = 1'b0;
    endtask

    task automatic test_ext_rollover();
        int exp_data[4] = '{1, 2, 3, 0};
        do_reset(2);
        en = 1'b1; cnt = 4'd0;
        tick();
        for (int w = 1; w <= 4; w++) begin
            cnt = 4'd8; tick();
            cnt = 4'd0; tick();
        end
        vectors++;
        if (ext_cnt2 !== 6'd0 || level2 !== 3'd4 || overflow2 !== 1'b0) begin
            miscompares++;
            $display("FAIL roll_ext got ext=%0d level=%0d ovf=%0b required 0/4/0", ext_cnt2, level2, overflow2);
        end
        cnt = 4'd8; tick();
        en = 1'b0;
        vectors++;
        if (ext_cnt2 !== 6'd8) begin
            miscompares++;
            $display("FAIL roll_ext_after got %0d required 8", ext_cnt2);
        end
        wrap_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (wrap_valid2 !== 1'b1 || wrap_data2 !== 2'(exp_data[k])) begin
                miscompares++;
                $display("FAIL roll_data[%0d] got valid=%0b data=%0d required 1/%0d",
                         k, wrap_valid2, wrap_data2, exp_data[k]);
            end
            tick();
        end
        wrap_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        en = 1'b1;
        cnt = 4'd5;  tick();
        cnt = 4'd0;  tick();
        cnt = 4'd15; tick();
        cnt = 4'd5;  tick();
        en = 1'b0;
        vectors++;
        if (ext_cnt !== 16'd37 || level !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_setup got ext=%0d level=%0d required 37/2", ext_cnt, level);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if ({ext_cnt, primed, wrap_valid, wrap_data, level, overflow} !== 34'd0) begin
            miscompares++;
            $display("FAIL mid_reset got ext=%0d primed=%0b valid=%0b data=%0d level=%0d ovf=%0b required all 0",
                     ext_cnt, primed, wrap_valid, wrap_data, level, overflow);
        end
        en = 1'b1; cnt = 4'd6;
        tick();
        en = 1'b0;
        tick();
        vectors++;
        if (ext_cnt !== 16'd6 || primed !== 1'b1 || level !== 3'd0 || wrap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reprime got ext=%0d primed=%0b level=%0d valid=%0b required 6/1/0/0",
                     ext_cnt, primed, level, wrap_valid);
        end
    endtask

    initial begin
        test_reset();
        test_prime_step();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_ext_rollover();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
